mod_operand_fetch: RTL and testbench

MOD_OPERAND_FETCH -- requirements
Module: mod_operand_fetch

---
 rtl/mod_operand_fetch.sv | 169 ++++++++++++++++
 tb/tb_mod_operand_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_operand_fetch.sv
// Operand fetch for the modulo unit: resolves immediate or register operands, applies the
// conditional-execution check and presents a held operand pair to the modulo stage.
module mod_operand_fetch #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned COND_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op1_is_reg,
    input  logic [31:0]          op1_val,
    input  logic                 op2_is_reg,
    input  logic [31:0]          op2_val,
    input  logic [ADDR_W-1:0]    dest_i,
    input  logic [COND_W-1:0]    cond_sel,
    input  logic [2**COND_W-1:0] flags_i,

    output logic                 rf_re,
    output logic [ADDR_W-1:0]    rf_raddr,
    input  logic [31:0]          rf_rdata,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_a,
    output logic [31:0]          out_b,
    output logic [ADDR_W-1:0]    out_dest,
    output logic                 div_zero_o,
    output logic                 skip_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StCap,
        StIssue,
        StSkip
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         out_a_q, out_a_d;
    logic [31:0]         out_b_q, out_b_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic                op1_reg_q, op1_reg_d;
    logic                op2_reg_q, op2_reg_d;

    logic accept;
    logic cond_pass;

    assign accept    = in_valid && in_ready;
    // Select 0 is the always-true condition, so flags_i[0] never matters.
    assign cond_pass = (cond_sel == '0) || flags_i[cond_sel];

    always_comb begin
        state_d   = state_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        dest_d    = dest_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        op1_reg_d = op1_reg_q;
        op2_reg_d = op2_reg_q;
        rf_re     = 1'b0;
        rf_raddr  = '0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    dest_d    = dest_i;
                    addr1_d   = op1_val[ADDR_W-1:0];
                    addr2_d   = op2_val[ADDR_W-1:0];
                    op1_reg_d = op1_is_reg;
                    op2_reg_d = op2_is_reg;
                    out_a_d   = op1_is_reg ? '0 : op1_val;
                    out_b_d   = op2_is_reg ? '0 : op2_val;
                    if (!cond_pass) begin
                        state_d = StSkip;
                    end else if (op1_is_reg) begin
                        state_d = StRdA;
                    end else if (op2_is_reg) begin
                        state_d = StRdB;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StRdA: begin
                rf_re    = 1'b1;
                rf_raddr = addr1_q;
                state_d  = op2_reg_q ? StRdB : StCap;
            end
            StRdB: begin
                rf_re    = 1'b1;
                rf_raddr = addr2_q;
                // The op1 read issued last cycle returns now, overlapping the op2 read.
                if (op1_reg_q) begin
                    out_a_d = rf_rdata;
                end
                state_d  = StCap;
            end
            StCap: begin
                if (op2_reg_q) begin
                    out_b_d = rf_rdata;
                end else begin
                    out_a_d = rf_rdata;
                end
                state_d = StIssue;
            end
            StIssue: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            StSkip: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            out_a_q   <= '0;
            out_b_q   <= '0;
            dest_q    <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            op1_reg_q <= 1'b0;
            op2_reg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            dest_q    <= dest_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            op1_reg_q <= op1_reg_d;
            op2_reg_q <= op2_reg_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StIssue);
    assign skip_o     = (state_q == StSkip);
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_dest   = dest_q;
    assign div_zero_o = out_valid && (out_b_q == '0);

`ifndef SYNTHESIS
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_a) && $stable(out_b)
                                      && $stable(out_dest)));

    a_skip_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        skip_o |=> !skip_o);
`endif

endmodule

// File: tb/tb_mod_operand_fetch.sv
// Scoreboard bench for mod_operand_fetch: expected operand pairs are queued at issue and
// popped when out_valid appears; read timing and latency are checked cycle by cycle.
module tb_mod_operand_fetch;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned COND_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 op1_is_reg;
    logic [31:0]          op1_val;
    logic                 op2_is_reg;
    logic [31:0]          op2_val;
    logic [ADDR_W-1:0]    dest_i;
    logic [COND_W-1:0]    cond_sel;
    logic [2**COND_W-1:0] flags_i;
    logic                 rf_re;
    logic [ADDR_W-1:0]    rf_raddr;
    logic [31:0]          rf_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_a;
    logic [31:0]          out_b;
    logic [ADDR_W-1:0]    out_dest;
    logic                 div_zero_o;
    logic                 skip_o;

    typedef struct packed {
        logic [31:0]       a;
        logic [31:0]       b;
        logic [ADDR_W-1:0] dest;
        logic              dz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf [256];
    int          n_checks;
    int          n_fail;

    mod_operand_fetch #(
        .ADDR_W (ADDR_W),
        .COND_W (COND_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1_is_reg (op1_is_reg),
        .op1_val    (op1_val),
        .op2_is_reg (op2_is_reg),
        .op2_val    (op2_val),
        .dest_i     (dest_i),
        .cond_sel   (cond_sel),
        .flags_i    (flags_i),
        .rf_re      (rf_re),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_dest   (out_dest),
        .div_zero_o (div_zero_o),
        .skip_o     (skip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous register file: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (rf_re) begin
            rf_rdata <= rf[rf_raddr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        op1_is_reg = 1'($urandom_range(0, 1));
        op2_is_reg = 1'($urandom_range(0, 1));
        op1_val    = $urandom;
        op2_val    = $urandom;
        dest_i     = ADDR_W'($urandom);
        cond_sel   = COND_W'($urandom);
        flags_i    = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".rf_re"}, 64'(rf_re), 64'd0);
        check({tag, ".skip_o"}, 64'(skip_o), 64'd0);
        check({tag, ".div_zero"}, 64'(div_zero_o), 64'd0);
        check({tag, ".out_a"}, 64'(out_a), 64'd0);
        check({tag, ".out_b"}, 64'(out_b), 64'd0);
        check({tag, ".out_dest"}, 64'(out_dest), 64'd0);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle following the instruction.
    task automatic run_instr(input logic r1, input logic [31:0] v1, input logic r2,
                             input logic [31:0] v2, input logic [ADDR_W-1:0] dest,
                             input logic [COND_W-1:0] cs, input logic [15:0] fl,
                             input int hold);
        logic              pass;
        int                nreads;
        int                lat;
        logic [ADDR_W-1:0] rd_addr [2];
        exp_t              e;
        exp_t              got;

        pass   = (cs == '0) || fl[cs];
        nreads = 0;
        if (r1) begin
            rd_addr[nreads] = v1[ADDR_W-1:0];
            nreads++;
        end
        if (r2) begin
            rd_addr[nreads] = v2[ADDR_W-1:0];
            nreads++;
        end
        lat = (nreads == 0) ? 1 : nreads + 2;

        if (pass) begin
            e.a    = r1 ? rf[v1[ADDR_W-1:0]] : v1;
            e.b    = r2 ? rf[v2[ADDR_W-1:0]] : v2;
            e.dest = dest;
            e.dz   = (e.b == 32'd0);
            sb.push_back(e);
        end

        in_valid   = 1'b1;
        op1_is_reg = r1;
        op1_val    = v1;
        op2_is_reg = r2;
        op2_val    = v2;
        dest_i     = dest;
        cond_sel   = cs;
        flags_i    = fl;
        check("accept.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        scramble_inputs();

        if (!pass) begin
            check("skip.skip_o", 64'(skip_o), 64'd1);
            check("skip.rf_re", 64'(rf_re), 64'd0);
            check("skip.out_valid", 64'(out_valid), 64'd0);
            step();
            check("skip.pulse_end", 64'(skip_o), 64'd0);
            check("skip.out_valid2", 64'(out_valid), 64'd0);
            check("skip.in_ready", 64'(in_ready), 64'd1);
            return;
        end

        for (int cyc = 1; cyc <= lat; cyc++) begin
            check("fetch.rf_re", 64'(rf_re), 64'(cyc <= nreads));
            if (cyc <= nreads) begin
                check("fetch.rf_raddr", 64'(rf_raddr), 64'(rd_addr[cyc-1]));
            end
            check("fetch.skip_o", 64'(skip_o), 64'd0);
            check("fetch.out_valid", 64'(out_valid), 64'(cyc == lat));
            if (cyc < lat) begin
                step();
            end
        end

        if (!out_valid) begin
            return;
        end
        if (sb.size() == 0) begin
            check("sb.empty", 64'd1, 64'd0);
            return;
        end
        got = sb.pop_front();

        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            check("issue.out_valid", 64'(out_valid), 64'd1);
            check("issue.in_ready", 64'(in_ready), 64'd0);
            check("issue.out_a", 64'(out_a), 64'(got.a));
            check("issue.out_b", 64'(out_b), 64'(got.b));
            check("issue.out_dest", 64'(out_dest), 64'(got.dest));
            check("issue.div_zero", 64'(div_zero_o), 64'(got.dz));
            step();
        end
        out_ready = 1'b0;
        check("done.out_valid", 64'(out_valid), 64'd0);
        check("done.in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rf_rdata  = 32'd0;
        scramble_inputs();
        for (int i = 0; i < 256; i++) begin
            rf[i] = $urandom;
        end
        rf[0] = 32'hCAFE_0000;
        rf[1] = 32'd0;
        rf[2] = 32'd13;
        rf[4] = 32'd100;
        rf[7] = 32'd9;

        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check("post_reset.in_ready", 64'(in_ready), 64'd1);

        // Both immediates
        run_instr(1'b0, 32'd17, 1'b0, 32'd5, 8'd3, 4'd0, 16'h0000, 0);
        // Both registers
        run_instr(1'b1, 32'd4, 1'b1, 32'd7, 8'd9, 4'd0, 16'h0000, 0);
        // Squashed by a clear flag
        run_instr(1'b0, 32'd1, 1'b0, 32'd2, 8'd5, 4'd2, 16'hFFFB, 0);
        // Immediate / zero register divisor, held for three cycles
        run_instr(1'b0, 32'd8, 1'b1, 32'd1, 8'd6, 4'd0, 16'h0000, 3);
        // Register 0 behaves as an ordinary register, condition passing on a set flag
        run_instr(1'b1, 32'd0, 1'b1, 32'd2, 8'd1, 4'd5, 16'h0020, 1);
        // Register dividend only, immediate zero divisor
        run_instr(1'b1, 32'd7, 1'b0, 32'd0, 8'd2, 4'd0, 16'h0000, 0);

        // Reset while the second read is in flight abandons the instruction
        in_valid   = 1'b1;
        op1_is_reg = 1'b1;
        op1_val    = 32'd4;
        op2_is_reg = 1'b1;
        op2_val    = 32'd7;
        dest_i     = 8'd11;
        cond_sel   = 4'd0;
        step();
        in_valid = 1'b0;
        check("abort.rd_a", 64'(rf_re), 64'd1);
        step();
        check("abort.rd_b", 64'(rf_re), 64'd1);
        check("abort.rd_b_addr", 64'(rf_raddr), 64'd7);
        rst_n = 1'b0;
        step();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort.no_valid", 64'(out_valid), 64'd0);
            check("abort.no_skip", 64'(skip_o), 64'd0);
        end

        for (int n = 0; n < 30; n++) begin
            logic        r1;
            logic        r2;
            logic [31:0] v1;
            logic [31:0] v2;
            logic [3:0]  cs;
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            v1 = r1 ? 32'($urandom_range(0, 15)) : $urandom;
            v2 = r2 ? 32'($urandom_range(0, 15)) : $urandom;
            if (!r2 && $urandom_range(0, 4) == 0) begin
                v2 = 32'd0;
            end
            cs = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_instr(r1, v1, r2, v2, 8'($urandom), cs, 16'($urandom),
                      int'($urandom_range(0, 2)));
        end

        check("sb.drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
